qupls4_regread_responder: RTL

// Serves the reservation stations' missing-operand read requests (req_pRn) against the physical register file.

---
 rtl/qupls4_regread_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/qupls4_regread_responder.sv
// Register-read responder: arbitrates reservation-station operand requests onto the RF read
// ports and broadcasts the returned values, forwarding RF writes that hit in-flight reads.
module qupls4_regread_responder #(
    parameter int NRS    = 4,
    parameter int NRP    = 4,
    parameter int NWR    = 4,
    parameter int RF_LAT = 1,
    parameter int PW     = 9,
    parameter int VW     = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [NRS*4*PW-1:0] req_pRn,
    output logic [NRP-1:0]      rf_re,
    output logic [NRP*PW-1:0]   rf_ra,
    input  logic [NRP*VW-1:0]   rf_rdata,
    input  logic [NRP-1:0]      rf_rtag,
    input  logic [NWR-1:0]      wr_v,
    input  logic [NWR*PW-1:0]   wr_pRd,
    input  logic [NWR*VW-1:0]   wr_val,
    input  logic [NWR-1:0]      wr_tag,
    output logic [NRP*PW-1:0]   prn,
    output logic [NRP-1:0]      prnv,
    output logic [NRP*VW-1:0]   rfo,
    output logic [NRP-1:0]      rfo_tag,
    output logic [7:0]          backlog
);
    localparam int NRQ   = NRS * 4;
    localparam int QW    = (NRQ > 1) ? $clog2(NRQ) : 1;
    localparam int DEPTH = RF_LAT + 1;

    typedef struct packed {
        logic          v;
        logic          cap;
        logic          tag;
        logic [PW-1:0] prn;
        logic [VW-1:0] val;
    } entry_t;

    typedef struct packed {
        logic          v;
        logic          tag;
        logic [PW-1:0] prn;
        logic [VW-1:0] val;
    } bcast_t;

    logic [PW-1:0] req     [NRQ];
    logic [PW-1:0] wpr     [NWR];
    logic [VW-1:0] wval    [NWR];
    entry_t        pipe    [DEPTH][NRP];
    entry_t        snp     [DEPTH][NRP];
    bcast_t        bc      [NRP];
    logic [PW-1:0] gnt_prn [NRP];
    int            gnt_n;
    int            last;
    int            pend;
    logic [QW-1:0] ptr;

    for (genvar i = 0; i < NRQ; i++) begin : g_req
        assign req[i] = req_pRn[i*PW +: PW];
    end

    for (genvar w = 0; w < NWR; w++) begin : g_wr
        assign wpr[w]  = wr_pRd[w*PW +: PW];
        assign wval[w] = wr_val[w*VW +: VW];
    end

    // Stage 0 of the in-flight pipe is the RF read request itself.
    for (genvar k = 0; k < NRP; k++) begin : g_port
        assign rf_re[k]             = pipe[0][k].v;
        assign rf_ra[k*PW +: PW]    = pipe[0][k].prn;
        assign prnv[k]              = bc[k].v;
        assign prn[k*PW +: PW]      = bc[k].prn;
        assign rfo[k*VW +: VW]      = bc[k].val;
        assign rfo_tag[k]           = bc[k].tag;
    end

    // Round-robin scan from ptr; equal pRn values collapse onto the first grant.
    always_comb begin : arb
        logic [PW-1:0] p;
        logic          busy;
        logic          dup;
        int            s;
        // NOTE: every variable written here gets a value before any conditional use, so no latches form.
        gnt_prn = '{default: '0};
        gnt_n   = 0;
        last    = 0;
        pend    = 0;
        p       = '0;
        busy    = 1'b0;
        dup     = 1'b0;
        s       = 0;
        for (int i = 0; i < NRQ; i++) begin
            s    = (int'(ptr) + i) % NRQ;
            p    = req[s[QW-1:0]];
            busy = 1'b0;
            dup  = 1'b0;
            for (int d = 0; d < DEPTH; d++)
                for (int k = 0; k < NRP; k++)
                    if (pipe[d][k].v && pipe[d][k].prn == p) busy = 1'b1;
            for (int k = 0; k < NRP; k++) begin
                if (bc[k].v && bc[k].prn == p) busy = 1'b1;
                if (k < gnt_n && gnt_prn[k] == p) dup = 1'b1;
            end
            if (p != '0 && !busy && !dup) begin
                if (!flush && gnt_n < NRP) begin
                    for (int k = 0; k < NRP; k++)
                        if (k == gnt_n) gnt_prn[k] = p;
                    gnt_n = gnt_n + 1;
                    last  = s;
                end else begin
                    pend = pend + 1;
                end
            end
        end
    end

    assign backlog = rst ? 8'd0 : (pend > 255) ? 8'd255 : 8'(pend);

    // Highest-numbered matching write port wins.
    always_comb begin : snoop
        snp = pipe;
        for (int d = 0; d < DEPTH; d++)
            for (int k = 0; k < NRP; k++)
                for (int w = 0; w < NWR; w++)
                    if (wr_v[w] && wpr[w] == pipe[d][k].prn) begin
                        snp[d][k].cap = 1'b1;
                        snp[d][k].val = wval[w];
                        snp[d][k].tag = wr_tag[w];
                    end
    end

    // NOTE: state registers use non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int d = 0; d < DEPTH; d++)
                for (int k = 0; k < NRP; k++)
                    pipe[d][k] <= '0;
            for (int k = 0; k < NRP; k++)
                bc[k] <= '0;
        end else begin
            for (int k = 0; k < NRP; k++) begin
                pipe[0][k] <= '{v: (k < gnt_n), cap: 1'b0, tag: 1'b0, prn: gnt_prn[k], val: '0};
                for (int d = 1; d < DEPTH; d++) begin
                    pipe[d][k]   <= snp[d-1][k];
                    pipe[d][k].v <= snp[d-1][k].v && !flush;
                end
                bc[k] <= '{v:   snp[DEPTH-1][k].v && !flush,
                           tag: snp[DEPTH-1][k].cap ? snp[DEPTH-1][k].tag : rf_rtag[k],
                           prn: snp[DEPTH-1][k].prn,
                           val: snp[DEPTH-1][k].cap ? snp[DEPTH-1][k].val : rf_rdata[k*VW +: VW]};
            end
            if (gnt_n != 0) ptr <= QW'((last + 1) % NRQ);
        end
    end

endmodule
